// File: rtl/imem_responder_pkg.sv
// imem_responder_pkg: shared types and constants for the instruction-memory responder.
//   state_e   - FSM encodings (IDLE/WAIT/RESP)
//   rsp_t     - registered response payload (error flag + instruction word)
//   addr_err  - misalignment / out-of-range check on a byte address
package imem_responder_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned WORD_BYTES = 4;
    localparam logic [DATA_W-1:0] ERR_WORD = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] data;
    } rsp_t;

    // Non-word-aligned or beyond the last stored word.
    function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                      input int unsigned       depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[ADDR_W-1:2]} >= depth);
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch-side request/response handshake bundle.
//   req_valid/req_addr/req_ready : request channel (fetch -> responder)
//   rsp_valid/rsp_data/rsp_err/rsp_ready : response channel (responder -> fetch)
//   master: fetch stage side, slave: responder side.
interface imem_responder_if;
    import imem_responder_pkg::*;

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/imem_responder_array.sv
// imem_array: DEPTH x 32 instruction storage.
//   clk      : clock, rising edge
//   we_i     : write strobe
//   waddr_i  : write word index
//   wdata_i  : write word
//   raddr_i  : read word index (combinational read)
//   rdata_o  : read word
// Contents are deliberately not reset. A read and write to the same word in
// one cycle returns the old word.
module imem_array
    import imem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Combinational read port.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_responder.sv
// imem_responder: single-outstanding instruction fetch responder with
// WAIT_CYCLES wait states, flush on PC redirect and a preload write port.
//   clk, rst              : clock and synchronous active-high reset
//   bus (slave)           : req_valid/req_addr/req_ready, rsp_valid/rsp_data/rsp_err/rsp_ready
//   flush                 : abandon the in-flight fetch, block new accepts
//   load_en/addr/data     : preload write, one word per cycle, any state
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    imem_responder_if.slave   bus,
    input  logic              flush,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    rsp_t               rsp_q, rsp_d;
    logic               rsp_valid_q, rsp_valid_d;

    logic [ADDR_W-1:0]  rd_addr_c;
    logic               rd_err_c;
    logic [DATA_W-1:0]  rd_data_c;
    logic               load_we_c;
    logic               unused_load_lsbs;

    // With zero wait states the array is read in the accept cycle itself,
    // so the read address bypasses the capture register while idle.
    assign rd_addr_c = (state_q == ST_IDLE) ? bus.req_addr : addr_q;
    assign rd_err_c  = addr_err(rd_addr_c, DEPTH);

    // Preloads outside the array are dropped; byte offset bits are ignored.
    assign load_we_c        = load_en && ({2'b00, load_addr[ADDR_W-1:2]} < DEPTH);
    assign unused_load_lsbs = ^load_addr[1:0];

    imem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (load_we_c),
        .waddr_i (load_addr[IDX_W+1:2]),
        .wdata_i (load_data),
        .raddr_i (rd_addr_c[IDX_W+1:2]),
        .rdata_o (rd_data_c)
    );

    // State and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Next-state, wait counter and response capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        rsp_d       = rsp_q;
        rsp_valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && !flush) begin
                    addr_d = bus.req_addr;
                    if (WAIT_CYCLES == 0) begin
                        rsp_d.err  = rd_err_c;
                        rsp_d.data = rd_err_c ? ERR_WORD : rd_data_c;
                        state_d    = ST_RESP;
                    end else begin
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                if (flush) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    rsp_d.err  = rd_err_c;
                    rsp_d.data = rd_err_c ? ERR_WORD : rd_data_c;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_RESP: begin
                if (flush || bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rsp_valid_d = (state_d == ST_RESP);
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_q.data;
    assign bus.rsp_err   = rsp_q.err;

endmodule
